mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS memory-access stage: data memory with byte/half/word loads and stores,
// sticky misalignment flag, and an optional memory dump engine (MEM_STAGE_DUMP_EN).
module mem_stage #(
    parameter int MEM_ADDR_WIDTH = 5
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_step,
    input  logic [31:0] i_address,
    input  logic [31:0] i_writedata,
    input  logic        i_memread,
    input  logic        i_memwrite,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_dataread,
    output logic        o_misaligned,
    input  logic        i_dump_req,
    input  logic        i_dump_ready,
    output logic [31:0] o_dump_data,
    output logic        o_dump_valid,
    output logic        o_dump_done,
    output logic        o_busy
);

    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;

    logic [31:0]               mem [DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] word_idx;
    logic [1:0]                lane;
    logic                      is_byte;
    logic                      is_half;
    logic                      is_word;
    logic                      misaligned;
    logic                      store_en;
    logic [3:0]                wmask;
    logic [31:0]               wdata;
    logic [31:0]               rdword;
    logic [7:0]                bsel;
    logic [15:0]               hsel;
    logic                      busy;

    assign word_idx = i_address[MEM_ADDR_WIDTH+1:2];
    assign lane     = i_address[1:0];
    assign is_byte  = (i_size == 2'b00);
    assign is_half  = (i_size == 2'b01);
    // Size 2'b10 is treated as a word access.
    assign is_word  = i_size[1];

    assign misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
    assign store_en   = i_memwrite && i_start && i_step && !busy && !misaligned;

    always_comb begin
        wmask = 4'b0000;
        wdata = i_writedata;
        if (is_byte) begin
            wmask = 4'b0001 << lane;
            wdata = {4{i_writedata[7:0]}};
        end else if (is_half) begin
            wmask = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{i_writedata[15:0]}};
        end else begin
            wmask = 4'b1111;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_misaligned <= 1'b0;
        end else if ((i_memread || i_memwrite) && i_start && i_step && misaligned) begin
            o_misaligned <= 1'b1;
        end
    end

    // Loads are combinational; with a simultaneous store they see pre-write data.
    always_comb begin
        rdword = mem[word_idx];
        unique case (lane)
            2'd0:    bsel = rdword[7:0];
            2'd1:    bsel = rdword[15:8];
            2'd2:    bsel = rdword[23:16];
            default: bsel = rdword[31:24];
        endcase
        hsel = lane[1] ? rdword[31:16] : rdword[15:0];
        o_dataread = '0;
        if (i_memread && !misaligned) begin
            if (is_byte) begin
                o_dataread = {{24{!i_unsigned && bsel[7]}}, bsel};
            end else if (is_half) begin
                o_dataread = {{16{!i_unsigned && hsel[15]}}, hsel};
            end else begin
                o_dataread = rdword;
            end
        end
    end

`ifdef MEM_STAGE_DUMP_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    dump_state_t               dump_state;
    dump_state_t               dump_state_next;
    logic [MEM_ADDR_WIDTH-1:0] dump_idx;
    logic                      accept;

    // Handshake: a word transfers on a rising edge where valid && ready;
    // data holds while valid && !ready and advances the cycle after transfer.
    assign accept = o_dump_valid && i_dump_ready;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            dump_state <= IDLE;
        end else begin
            dump_state <= dump_state_next;
        end
    end

    always_comb begin
        dump_state_next = dump_state;
        unique case (dump_state)
            IDLE:    if (i_dump_req) dump_state_next = DUMP;
            DUMP:    if (accept && (&dump_idx)) dump_state_next = DONE;
            DONE:    dump_state_next = IDLE;
            default: dump_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_dump_valid = (dump_state == DUMP);
        o_dump_done  = (dump_state == DONE);
        busy         = (dump_state != IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            dump_idx <= '0;
        end else if (dump_state == IDLE && i_dump_req) begin
            dump_idx <= '0;
        end else if (dump_state == DUMP && accept) begin
            dump_idx <= dump_idx + 1'b1;
        end
    end

    assign o_dump_data = o_dump_valid ? mem[dump_idx] : '0;

    logic unused_bits;
    assign unused_bits = ^i_address[31:MEM_ADDR_WIDTH+2];
`else
    assign busy         = 1'b0;
    assign o_dump_valid = 1'b0;
    assign o_dump_done  = 1'b0;
    assign o_dump_data  = '0;

    logic unused_bits;
    assign unused_bits = ^{i_address[31:MEM_ADDR_WIDTH+2], i_dump_req, i_dump_ready};
`endif

    assign o_busy = busy;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for load extension, hand sequences
// for stores, misalignment, dump handshake and asynchronous reset.
module tb_mem_stage;

    logic        clock;
    logic        reset;
    logic        start;
    logic        step;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        memread;
    logic        memwrite;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] dataread;
    logic        misaligned;
    logic        dump_req;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic        dump_valid;
    logic        dump_done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic        rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    mem_stage #(.MEM_ADDR_WIDTH(5)) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_start      (start),
        .i_step       (step),
        .i_address    (address),
        .i_writedata  (writedata),
        .i_memread    (memread),
        .i_memwrite   (memwrite),
        .i_size       (size),
        .i_unsigned   (uns),
        .o_dataread   (dataread),
        .o_misaligned (misaligned),
        .i_dump_req   (dump_req),
        .i_dump_ready (dump_ready),
        .o_dump_data  (dump_data),
        .o_dump_valid (dump_valid),
        .o_dump_done  (dump_done),
        .o_busy       (busy)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        step      = 1'b0;
        address   = '0;
        writedata = '0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        size      = 2'b11;
        uns       = 1'b0;
    endtask

    // Driver tasks: inputs change on the falling edge, outputs sampled 1 ns later.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input logic st, input logic sp);
        @(negedge clock);
        start = st; step = sp; address = a; writedata = d; size = sz;
        memwrite = 1'b1; memread = 1'b0;
        @(negedge clock);
        memwrite = 1'b0;
    endtask

    task automatic load_check(input string name, input logic [31:0] a, input logic [1:0] sz,
                              input logic u, input logic rd, input logic [31:0] exp);
        @(negedge clock);
        start = 1'b1; step = 1'b1; address = a; size = sz; uns = u;
        memread = rd; memwrite = 1'b0;
        #1;
        check(name, dataread, exp);
    endtask

    initial begin
        vecs[0]  = '{"lb_0x4",    32'h04, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[1]  = '{"lbu_0x4",   32'h04, 2'b00, 1'b1, 1'b1, 32'h0000_00FF};
        vecs[2]  = '{"lb_0x5",    32'h05, 2'b00, 1'b0, 1'b1, 32'h0000_0000};
        vecs[3]  = '{"lb_0x7",    32'h07, 2'b00, 1'b0, 1'b1, 32'hFFFF_FF80};
        vecs[4]  = '{"lbu_0x7",   32'h07, 2'b00, 1'b1, 1'b1, 32'h0000_0080};
        vecs[5]  = '{"lh_0x6",    32'h06, 2'b01, 1'b0, 1'b1, 32'hFFFF_8000};
        vecs[6]  = '{"lhu_0x6",   32'h06, 2'b01, 1'b1, 1'b1, 32'h0000_8000};
        vecs[7]  = '{"lh_0x4",    32'h04, 2'b01, 1'b0, 1'b1, 32'h0000_00FF};
        vecs[8]  = '{"lw_0x4",    32'h04, 2'b11, 1'b0, 1'b1, 32'h8000_00FF};
        vecs[9]  = '{"lw_wrap",   32'h84, 2'b11, 1'b0, 1'b1, 32'h8000_00FF};
        vecs[10] = '{"lw_sz10",   32'h04, 2'b10, 1'b0, 1'b1, 32'h8000_00FF};
        vecs[11] = '{"lw_uns",    32'h04, 2'b11, 1'b1, 1'b1, 32'h8000_00FF};
        vecs[12] = '{"no_read",   32'h04, 2'b11, 1'b0, 1'b0, 32'h0000_0000};

        idle_inputs();
        reset      = 1'b0;
        dump_req   = 1'b0;
        dump_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Reset state
        load_check("reset_lw0", 32'h0, 2'b11, 1'b0, 1'b1, 32'h0);
        check("reset_misaligned", {31'b0, misaligned}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_dump_valid", {31'b0, dump_valid}, 32'h0);
        check("reset_dump_done", {31'b0, dump_done}, 32'h0);
        check("reset_dump_data", dump_data, 32'h0);

        // Word store then table of lane/extension loads
        store(32'h4, 32'h8000_00FF, 2'b11, 1'b1, 1'b1);
        for (int i = 0; i < 13; i++) begin
            load_check(vecs[i].name, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].rd, vecs[i].exp);
        end

        // Byte/half stores, gating by step/start, read-during-write
        store(32'h9, 32'h1234_56AB, 2'b00, 1'b1, 1'b1);
        load_check("sb_0x9", 32'h8, 2'b11, 1'b0, 1'b1, 32'h0000_AB00);
        store(32'hD, 32'h0000_00AB, 2'b00, 1'b1, 1'b0);
        load_check("sb_nostep", 32'hC, 2'b11, 1'b0, 1'b1, 32'h0);
        store(32'hD, 32'h0000_00AB, 2'b00, 1'b0, 1'b1);
        load_check("sb_nostart", 32'hC, 2'b11, 1'b0, 1'b1, 32'h0);
        store(32'h12, 32'hFFFF_BEEF, 2'b01, 1'b1, 1'b1);
        load_check("sh_0x12", 32'h10, 2'b11, 1'b0, 1'b1, 32'hBEEF_0000);

        @(negedge clock);
        start = 1'b1; step = 1'b1; address = 32'h10; size = 2'b11;
        writedata = 32'h1111_1111; memread = 1'b1; memwrite = 1'b1;
        #1;
        check("rw_prewrite", dataread, 32'hBEEF_0000);
        @(negedge clock);
        memwrite = 1'b0;
        #1;
        check("rw_postwrite", dataread, 32'h1111_1111);

        // Misalignment: no flag without start, then sticky flag and suppressed stores
        @(negedge clock);
        start = 1'b0; step = 1'b1; address = 32'h6; size = 2'b11; memread = 1'b1;
        @(negedge clock);
        check("mis_nostart_flag", {31'b0, misaligned}, 32'h0);
        load_check("lw_mis_0x6", 32'h6, 2'b11, 1'b0, 1'b1, 32'h0);
        @(negedge clock);
        memread = 1'b0;
        check("mis_flag_set", {31'b0, misaligned}, 32'h1);
        store(32'h1, 32'h0000_1234, 2'b01, 1'b1, 1'b1);
        load_check("sh_mis_0x1", 32'h0, 2'b11, 1'b0, 1'b1, 32'h0);
        store(32'h5, 32'h0000_1234, 2'b01, 1'b1, 1'b1);
        store(32'h6, 32'h5555_5555, 2'b11, 1'b1, 1'b1);
        load_check("st_mis_word1", 32'h4, 2'b11, 1'b0, 1'b1, 32'h8000_00FF);
        load_check("lh_mis_0x5", 32'h5, 2'b01, 1'b0, 1'b1, 32'h0);
        check("mis_flag_sticky", {31'b0, misaligned}, 32'h1);

        // Preload every word with its index, read back through the scoreboard
        for (int i = 0; i < 32; i++) begin
            store(i * 4, i, 2'b11, 1'b1, 1'b1);
            exp_q.push_back(i);
        end
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            load_check("preload_rd", i * 4, 2'b11, 1'b0, 1'b1, e);
        end
        @(negedge clock);
        idle_inputs();

`ifdef MEM_STAGE_DUMP_EN
        begin
            int got;
            int dones;
            logic [31:0] held;
            logic hold_v;
            got = 0; dones = 0; hold_v = 1'b0;
            for (int i = 0; i < 32; i++) exp_q.push_back(i);
            dump_req = 1'b1; dump_ready = 1'b0;
            @(negedge clock);
            dump_req = 1'b0;
            for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
                if (dump_done) begin
                    dones++;
                    check("busy_in_done", {31'b0, busy}, 32'h1);
                end
                if (dump_valid) begin
                    check("busy_in_dump", {31'b0, busy}, 32'h1);
                    if (hold_v) check("dump_stable", dump_data, held);
                    if (dump_ready) begin
                        if (exp_q.size() > 0) check("dump_word", dump_data, exp_q.pop_front());
                        got++;
                        hold_v = 1'b0;
                    end else begin
                        held = dump_data;
                        hold_v = 1'b1;
                    end
                end
                dump_ready = cyc[0];
                if (cyc == 4) begin
                    start = 1'b1; step = 1'b1; address = 32'h14; size = 2'b11;
                    writedata = 32'h0000_DEAD; memwrite = 1'b1;
                end else begin
                    memwrite = 1'b0;
                end
                @(negedge clock);
            end
            check("dump_done_seen", dones, 1);
            check("dump_count", got, 32);
            check("dump_q_empty", exp_q.size(), 0);
            check("done_one_cycle", {31'b0, dump_done}, 32'h0);
            check("busy_after", {31'b0, busy}, 32'h0);
            dump_ready = 1'b0;
            load_check("store_blocked", 32'h14, 2'b11, 1'b0, 1'b1, 32'h5);
            @(negedge clock);
            idle_inputs();

            // Asynchronous reset in the middle of a dump
            got = 0;
            dump_req = 1'b1; dump_ready = 1'b1;
            @(negedge clock);
            dump_req = 1'b0;
            for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
                if (dump_valid) got++;
                @(negedge clock);
            end
            check("mid_dump_reached", got, 10);
            #2 reset = 1'b0;
            #1;
            check("rst_valid", {31'b0, dump_valid}, 32'h0);
            check("rst_busy", {31'b0, busy}, 32'h0);
            check("rst_done", {31'b0, dump_done}, 32'h0);
            check("rst_dump_data", dump_data, 32'h0);
            @(negedge clock);
            reset = 1'b1;

            got = 0; dones = 0;
            dump_req = 1'b1;
            @(negedge clock);
            dump_req = 1'b0;
            for (int cyc = 0; cyc < 100 && dones == 0; cyc++) begin
                if (dump_done) dones++;
                if (dump_valid) begin
                    check("redump_word", dump_data, 32'h0);
                    got++;
                end
                @(negedge clock);
            end
            check("redump_done", dones, 1);
            check("redump_count", got, 32);
            dump_ready = 1'b0;
        end
`else
        @(negedge clock);
        dump_req = 1'b1; dump_ready = 1'b1;
        start = 1'b1; step = 1'b1; address = 32'h14; size = 2'b11;
        writedata = 32'h0000_DEAD; memwrite = 1'b1;
        #1;
        check("nodump_busy", {31'b0, busy}, 32'h0);
        check("nodump_valid", {31'b0, dump_valid}, 32'h0);
        @(negedge clock);
        memwrite = 1'b0; dump_req = 1'b0;
        check("nodump_done", {31'b0, dump_done}, 32'h0);
        check("nodump_data", dump_data, 32'h0);
        load_check("nodump_store", 32'h14, 2'b11, 1'b0, 1'b1, 32'h0000_DEAD);
`endif

        // Asynchronous reset mid-cycle clears memory and the sticky flag
        store(32'h18, 32'h5A5A_5A5A, 2'b11, 1'b1, 1'b1);
        load_check("pre_reset_rd", 32'h18, 2'b11, 1'b0, 1'b1, 32'h5A5A_5A5A);
        #2 reset = 1'b0;
        #1;
        check("async_rst_mem", dataread, 32'h0);
        check("async_rst_flag", {31'b0, misaligned}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        load_check("post_reset_w1", 32'h4, 2'b11, 1'b0, 1'b1, 32'h0);
        @(negedge clock);
        idle_inputs();

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
